sound_dac_array: RTL and testbench

Multi-channel 1-bit sound output block for the cartridge boards. It replaces the per-channel 1-bit DAC instances and the shared DAC clock-enable divider in the board top with a single parametrised block. Each channel has:
- a sample hold register
- a ramped gain/mute stage with saturation
- a first- or second-order delta-sigma modulator driving one output pin

All channels run on `CLK_BASE` (108 MHz) and update on a common internal enable.

---
 rtl/sound_dac_array.sv | 188 ++++++++++++++++++
 tb/tb_sound_dac_array.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_dac_array.sv
// Multi-channel 1-bit sound DAC: per-channel sample hold, ramped gain with
// saturation, and a first- or second-order delta-sigma modulator on a shared tick.
module sound_dac_array #(
    parameter int CHANNELS  = 2,
    parameter int BIT_WIDTH = 16,
    parameter int DIV       = 5,
    parameter int ORDER     = 1,
    parameter int RAMP_DIV  = 256
) (
    input  logic                          CLK_BASE,
    input  logic                          RESET_n,
    input  logic [CHANNELS*BIT_WIDTH-1:0] SAMPLE,
    input  logic [CHANNELS-1:0]           SAMPLE_STB,
    input  logic [CHANNELS*8-1:0]         GAIN,
    input  logic [CHANNELS-1:0]           MUTE,
    output logic [CHANNELS-1:0]           OUT,
    output logic [CHANNELS-1:0]           CLIP,
    output logic                          TICK
);

    localparam int BW = BIT_WIDTH;
    localparam int PW = BW + 9;
    localparam int IW = BW + 4;
    localparam int EW = IW + 2;
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
    localparam logic [RW-1:0] RAMP_MAX = RW'(RAMP_DIV - 1);

    if (ORDER != 1 && ORDER != 2) begin : g_bad_order
        $error("sound_dac_array: ORDER must be 1 or 2");
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] ramp_q, ramp_d;
    logic          tick;
    logic          ramp_step;

    assign tick      = (cnt_q == '0);
    assign ramp_step = tick && (ramp_q == '0);
    assign TICK      = tick;

    always_comb begin
        cnt_d  = tick ? CNT_MAX : cnt_q - CW'(1);
        ramp_d = ramp_q;
        if (tick) begin
            ramp_d = (ramp_q == '0) ? RAMP_MAX : ramp_q - RW'(1);
        end
    end

    always_ff @(posedge CLK_BASE or negedge RESET_n) begin
        if (!RESET_n) begin
            cnt_q  <= CNT_MAX;
            ramp_q <= RAMP_MAX;
        end else begin
            cnt_q  <= cnt_d;
            ramp_q <= ramp_d;
        end
    end

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        localparam logic signed [PW-1:0] S_MAX = PW'((1 << (BW - 1)) - 1);
        localparam logic signed [PW-1:0] S_MIN = PW'(-(1 << (BW - 1)));

        logic signed [BW-1:0] hold_q;
        logic [7:0]           gain_q, gain_d, target;
        logic signed [PW-1:0] prod, shifted;
        logic signed [BW-1:0] s;
        logic                 sat;
        logic                 out_q, out_d, clip_q, clip_d;

        assign target = MUTE[n] ? 8'd0 : GAIN[n*8 +: 8];

        always_comb begin
            gain_d = gain_q;
            if (ramp_step) begin
                if (gain_q < target) begin
                    gain_d = gain_q + 8'd1;
                end else if (gain_q > target) begin
                    gain_d = gain_q - 8'd1;
                end
            end
        end

        // Gain is Q1.7 unsigned, so the product is rescaled by 2^7.
        assign prod    = PW'(hold_q) * PW'($signed({1'b0, gain_q}));
        assign shifted = prod >>> 7;

        always_comb begin
            sat = 1'b0;
            s   = shifted[BW-1:0];
            if (shifted > S_MAX) begin
                s   = {1'b0, {(BW - 1){1'b1}}};
                sat = 1'b1;
            end else if (shifted < S_MIN) begin
                s   = {1'b1, {(BW - 1){1'b0}}};
                sat = 1'b1;
            end
        end

        assign clip_d = tick && sat;

        if (ORDER == 1) begin : g_ord1
            logic [BW-1:0] acc_q, acc_d;
            logic [BW-1:0] u;
            logic [BW:0]   sum;

            assign u   = {~s[BW-1], s[BW-2:0]};
            assign sum = {1'b0, acc_q} + {1'b0, u};

            always_comb begin
                acc_d = acc_q;
                out_d = out_q;
                if (tick) begin
                    acc_d = sum[BW-1:0];
                    out_d = sum[BW];
                end
            end

            always_ff @(posedge CLK_BASE or negedge RESET_n) begin
                if (!RESET_n) begin
                    acc_q <= '0;
                end else begin
                    acc_q <= acc_d;
                end
            end
        end else if (ORDER == 2) begin : g_ord2
            localparam logic signed [EW-1:0] I_MAX  = EW'((1 << (IW - 1)) - 1);
            localparam logic signed [EW-1:0] I_MIN  = EW'(-(1 << (IW - 1)));
            localparam logic signed [EW-1:0] FB_POS = EW'(1 << (BW - 1));
            localparam logic signed [EW-1:0] FB_NEG = EW'(-(1 << (BW - 1)));

            logic signed [IW-1:0] i1_q, i1_d, i2_q, i2_d;
            logic signed [EW-1:0] fb, sum1, sum2;

            assign fb   = out_q ? FB_POS : FB_NEG;
            assign sum1 = EW'(i1_q) + EW'(s) - fb;
            assign sum2 = EW'(i2_q) + EW'(i1_q) - fb;

            // Integrators clamp instead of wrapping so a long mute cannot flip their sign.
            always_comb begin
                i1_d  = i1_q;
                i2_d  = i2_q;
                out_d = out_q;
                if (tick) begin
                    if (sum1 > I_MAX)      i1_d = IW'(I_MAX);
                    else if (sum1 < I_MIN) i1_d = IW'(I_MIN);
                    else                   i1_d = sum1[IW-1:0];
                    if (sum2 > I_MAX)      i2_d = IW'(I_MAX);
                    else if (sum2 < I_MIN) i2_d = IW'(I_MIN);
                    else                   i2_d = sum2[IW-1:0];
                    out_d = ~sum2[EW-1];
                end
            end

            always_ff @(posedge CLK_BASE or negedge RESET_n) begin
                if (!RESET_n) begin
                    i1_q <= '0;
                    i2_q <= '0;
                end else begin
                    i1_q <= i1_d;
                    i2_q <= i2_d;
                end
            end
        end

        always_ff @(posedge CLK_BASE or negedge RESET_n) begin
            if (!RESET_n) begin
                hold_q <= '0;
                gain_q <= '0;
                out_q  <= 1'b0;
                clip_q <= 1'b0;
            end else begin
                if (SAMPLE_STB[n]) begin
                    hold_q <= SAMPLE[n*BIT_WIDTH +: BIT_WIDTH];
                end
                gain_q <= gain_d;
                out_q  <= out_d;
                clip_q <= clip_d;
            end
        end

        assign OUT[n]  = out_q;
        assign CLIP[n] = clip_q;
    end

endmodule

// File: tb/tb_sound_dac_array.sv
// Bench for sound_dac_array: a first-order and a second-order instance run side by
// side against an arithmetic per-tick model, plus density and timing checks.
module tb_sound_dac_array;

    localparam int BW     = 16;
    localparam int NC     = 2;
    localparam int NI     = 2;
    localparam int DIV_A  = 5;
    localparam int DIV_B  = 2;
    localparam int RDIV_A = 1;
    localparam int RDIV_B = 4;
    localparam longint SMAX = (longint'(1) << (BW - 1)) - 1;
    localparam longint SMIN = -(longint'(1) << (BW - 1));
    localparam longint IMAX = (longint'(1) << (BW + 3)) - 1;
    localparam longint IMIN = -(longint'(1) << (BW + 3));

    logic             clk_base;
    logic             reset_n;
    logic [NC*BW-1:0] samp_a, samp_b;
    logic [NC-1:0]    stb_a, stb_b, mute_a, mute_b;
    logic [NC*8-1:0]  gain_a, gain_b;
    logic [NC-1:0]    out_a, out_b, clip_a, clip_b;
    logic             tick_a, tick_b;

    sound_dac_array #(.CHANNELS(NC), .BIT_WIDTH(BW), .DIV(DIV_A), .ORDER(1), .RAMP_DIV(RDIV_A)) u_dut_a (
        .CLK_BASE(clk_base), .RESET_n(reset_n), .SAMPLE(samp_a), .SAMPLE_STB(stb_a),
        .GAIN(gain_a), .MUTE(mute_a), .OUT(out_a), .CLIP(clip_a), .TICK(tick_a));

    sound_dac_array #(.CHANNELS(NC), .BIT_WIDTH(BW), .DIV(DIV_B), .ORDER(2), .RAMP_DIV(RDIV_B)) u_dut_b (
        .CLK_BASE(clk_base), .RESET_n(reset_n), .SAMPLE(samp_b), .SAMPLE_STB(stb_b),
        .GAIN(gain_b), .MUTE(mute_b), .OUT(out_b), .CLIP(clip_b), .TICK(tick_b));

    initial begin
        clk_base = 1'b0;
        forever #5 clk_base = ~clk_base;
    end

    int     checks;
    int     errors;
    int     m_cnt  [NI];
    int     m_ramp [NI];
    int     ticks_a;
    int     ticks_b;
    bit     last_tick [NI];
    longint m_hold [NI][NC];
    longint m_gain [NI][NC];
    longint m_acc  [NI][NC];
    longint m_i1   [NI][NC];
    longint m_i2   [NI][NC];
    bit     m_out  [NI][NC];
    bit     m_clip [NI][NC];
    logic [9:0] obs, want;

    function automatic int div_of(int k);
        return (k == 0) ? DIV_A : DIV_B;
    endfunction

    function automatic int rdiv_of(int k);
        return (k == 0) ? RDIV_A : RDIV_B;
    endfunction

    function automatic longint in_sample(int k, int n);
        logic [BW-1:0] v;
        v = (k == 0) ? samp_a[n*BW +: BW] : samp_b[n*BW +: BW];
        return longint'($signed(v));
    endfunction

    function automatic longint in_target(int k, int n);
        logic m;
        logic [7:0] g;
        m = (k == 0) ? mute_a[n] : mute_b[n];
        g = (k == 0) ? gain_a[n*8 +: 8] : gain_b[n*8 +: 8];
        return m ? 0 : longint'(g);
    endfunction

    function automatic bit in_stb(int k, int n);
        return (k == 0) ? stb_a[n] : stb_b[n];
    endfunction

    function automatic longint clamp_i(longint v);
        if (v > IMAX) return IMAX;
        if (v < IMIN) return IMIN;
        return v;
    endfunction

    function automatic logic [9:0] exp_vec();
        logic [9:0] v;
        v[9]   = (m_cnt[1] == 0);
        v[8]   = (m_cnt[0] == 0);
        v[7:6] = {m_out[1][1], m_out[1][0]};
        v[5:4] = {m_out[0][1], m_out[0][0]};
        v[3:2] = {m_clip[1][1], m_clip[1][0]};
        v[1:0] = {m_clip[0][1], m_clip[0][0]};
        return v;
    endfunction

    task automatic model_reset();
        ticks_a = 0;
        ticks_b = 0;
        for (int k = 0; k < NI; k++) begin
            m_cnt[k]     = div_of(k) - 1;
            m_ramp[k]    = rdiv_of(k) - 1;
            last_tick[k] = 1'b0;
            for (int n = 0; n < NC; n++) begin
                m_hold[k][n] = 0; m_gain[k][n] = 0; m_acc[k][n] = 0;
                m_i1[k][n]   = 0; m_i2[k][n]   = 0;
                m_out[k][n]  = 1'b0; m_clip[k][n] = 1'b0;
            end
        end
    endtask

    // Advance the model by one clock edge using the inputs as they stand now.
    task automatic model_edge();
        for (int k = 0; k < NI; k++) begin
            bit     tk, step;
            longint p, s, sum, fb, t1, t2, tgt;
            tk           = (m_cnt[k] == 0);
            step         = tk && (m_ramp[k] == 0);
            last_tick[k] = tk;
            if (tk && k == 0) ticks_a++;
            if (tk && k == 1) ticks_b++;
            for (int n = 0; n < NC; n++) begin
                m_clip[k][n] = 1'b0;
                if (tk) begin
                    p = m_hold[k][n] * m_gain[k][n];
                    s = p >>> 7;
                    if (s > SMAX) begin s = SMAX; m_clip[k][n] = 1'b1; end
                    else if (s < SMIN) begin s = SMIN; m_clip[k][n] = 1'b1; end
                    if (k == 0) begin
                        sum          = m_acc[k][n] + s - SMIN;
                        m_out[k][n]  = (sum >= 2 * (SMAX + 1));
                        m_acc[k][n]  = sum % (2 * (SMAX + 1));
                    end else begin
                        fb          = m_out[k][n] ? (SMAX + 1) : SMIN;
                        t1          = m_i1[k][n] + s - fb;
                        t2          = m_i2[k][n] + m_i1[k][n] - fb;
                        m_i1[k][n]  = clamp_i(t1);
                        m_i2[k][n]  = clamp_i(t2);
                        m_out[k][n] = (t2 >= 0);
                    end
                end
                if (step) begin
                    tgt = in_target(k, n);
                    if (m_gain[k][n] < tgt) m_gain[k][n]++;
                    else if (m_gain[k][n] > tgt) m_gain[k][n]--;
                end
                if (in_stb(k, n)) m_hold[k][n] = in_sample(k, n);
            end
            if (tk) m_ramp[k] = (m_ramp[k] == 0) ? rdiv_of(k) - 1 : m_ramp[k] - 1;
            m_cnt[k] = tk ? div_of(k) - 1 : m_cnt[k] - 1;
        end
    endtask

    task automatic clk_step();
        model_edge();
        @(posedge clk_base);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        samp_a = '0; samp_b = '0; stb_a = '0; stb_b = '0;
        mute_a = '0; mute_b = '0;
        gain_a = {8'd255, 8'd128};
        gain_b = {8'd200, 8'd128};
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_base);
            #1;
            obs = {tick_b, tick_a, out_b, out_a, clip_b, clip_a};
            checks++;
            if (obs !== 10'b0) begin
                errors++;
                $display("FAIL reset_values got=%b want=%b", obs, 10'b0);
            end
        end
        reset_n = 1'b1;
    endtask

    task automatic test_tick_period();
        for (int e = 1; e <= 20; e++) begin
            clk_step();
            checks++;
            if (tick_a !== ((e % DIV_A) == DIV_A - 1) || tick_b !== ((e % DIV_B) == DIV_B - 1)) begin
                errors++;
                $display("FAIL tick_period edge=%0d got=%b%b", e, tick_a, tick_b);
            end
            obs = {tick_b, tick_a, out_b, out_a, clip_b, clip_a}; want = exp_vec();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL tick_stream edge=%0d got=%b want=%b", e, obs, want);
            end
        end
    endtask

    task automatic test_unity_zero();
        int ones, nt;
        while (ticks_a < 128) begin
            clk_step();
            obs = {tick_b, tick_a, out_b, out_a, clip_b, clip_a}; want = exp_vec();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL unity_ramp t=%0t got=%b want=%b", $time, obs, want);
            end
        end
        ones = 0; nt = 0;
        while (nt < 1024) begin
            clk_step();
            obs = {tick_b, tick_a, out_b, out_a, clip_b, clip_a}; want = exp_vec();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL unity_stream t=%0t got=%b want=%b", $time, obs, want);
            end
            if (last_tick[0]) begin
                nt++;
                ones += int'(out_a[0]);
            end
        end
        checks++;
        if (ones !== 512) begin
            errors++;
            $display("FAIL unity_density ones=%0d want=512", ones);
        end
    endtask

    task automatic test_strobe_on_tick();
        for (int i = 0; i < DIV_A && m_cnt[0] != 0; i++) clk_step();
        samp_a[BW +: BW] = 16'h7FFF;
        stb_a = 2'b10;
        clk_step();
        stb_a = 2'b00;
        checks++;
        if (clip_a[1] !== 1'b0) begin
            errors++;
            $display("FAIL strobe_old_value clip=%b want=0", clip_a[1]);
        end
        for (int i = 1; i <= DIV_A; i++) begin
            clk_step();
            checks++;
            if (clip_a[1] !== (i == DIV_A)) begin
                errors++;
                $display("FAIL strobe_new_value step=%0d clip=%b want=%b", i, clip_a[1], i == DIV_A);
            end
        end
    endtask

    task automatic test_saturation();
        int ones, clips, nt;
        ones = 0; clips = 0; nt = 0;
        while (nt < 1024) begin
            clk_step();
            obs = {tick_b, tick_a, out_b, out_a, clip_b, clip_a}; want = exp_vec();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL sat_stream t=%0t got=%b want=%b", $time, obs, want);
            end
            if (last_tick[0]) begin
                nt++;
                ones  += int'(out_a[1]);
                clips += int'(clip_a[1]);
            end
        end
        checks++;
        if (clips !== 1024) begin
            errors++;
            $display("FAIL sat_clip_count clips=%0d want=1024", clips);
        end
        checks++;
        if (ones < 1023) begin
            errors++;
            $display("FAIL sat_density ones=%0d want>=1023", ones);
        end
    endtask

    task automatic test_mute_fade();
        int ones, nt;
        samp_a[0 +: BW] = 16'h4000;
        stb_a = 2'b01;
        clk_step();
        stb_a = 2'b00;
        for (int phase = 0; phase < 2; phase++) begin
            mute_a[0] = (phase == 0);
            ones = 0; nt = 0;
            while (nt < 130 + 1024) begin
                clk_step();
                obs = {tick_b, tick_a, out_b, out_a, clip_b, clip_a}; want = exp_vec();
                checks++;
                if (obs !== want) begin
                    errors++;
                    $display("FAIL fade_stream ph=%0d t=%0t got=%b want=%b", phase, $time, obs, want);
                end
                if (last_tick[0]) begin
                    nt++;
                    if (nt > 130) ones += int'(out_a[0]);
                end
            end
            checks++;
            if (ones !== ((phase == 0) ? 512 : 768)) begin
                errors++;
                $display("FAIL fade_density ph=%0d ones=%0d want=%0d", phase, ones, (phase == 0) ? 512 : 768);
            end
        end
    endtask

    task automatic test_order2();
        int start;
        samp_b = {16'h1234, 16'hA000};
        stb_b = 2'b11;
        clk_step();
        stb_b = 2'b00;
        start = ticks_b;
        for (int ph = 0; ph < 3; ph++) begin
            if (ph == 1) mute_b[1] = 1'b1;
            if (ph == 2) mute_b[1] = 1'b0;
            while (ticks_b < start + 8192 + ph * 1000) begin
                clk_step();
                obs = {tick_b, tick_a, out_b, out_a, clip_b, clip_a}; want = exp_vec();
                checks++;
                if (obs !== want) begin
                    errors++;
                    $display("FAIL order2_stream ph=%0d t=%0t got=%b want=%b", ph, $time, obs, want);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            if (c % 256 == 0) begin
                gain_a = NC*8'($urandom); gain_b = NC*8'($urandom);
                mute_a = NC'($urandom_range(0, 3) == 0 ? 1 : 0);
                mute_b = NC'($urandom_range(0, 3));
            end
            samp_a = (NC*BW)'({$urandom, $urandom});
            samp_b = (NC*BW)'({$urandom, $urandom});
            stb_a  = {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0};
            stb_b  = {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0};
            clk_step();
            obs = {tick_b, tick_a, out_b, out_a, clip_b, clip_a}; want = exp_vec();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL random_stream c=%0d got=%b want=%b", c, obs, want);
            end
        end
        stb_a = '0; stb_b = '0;
    endtask

    task automatic test_async_reset();
        int guard;
        samp_a[BW +: BW] = 16'h7FFF;
        stb_a  = 2'b10;
        mute_a = '0;
        gain_a = {8'd255, 8'd128};
        clk_step();
        stb_a = '0;
        guard = 0;
        while (!m_clip[0][1] && guard < 2000) begin
            clk_step();
            guard++;
        end
        checks++;
        if (!m_clip[0][1] || clip_a[1] !== 1'b1) begin
            errors++;
            $display("FAIL async_setup clip=%b guard=%0d", clip_a[1], guard);
        end
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        obs = {tick_b, tick_a, out_b, out_a, clip_b, clip_a};
        checks++;
        if (obs !== 10'b0) begin
            errors++;
            $display("FAIL async_reset_immediate got=%b want=%b", obs, 10'b0);
        end
        @(posedge clk_base);
        #1;
        reset_n = 1'b1;
        for (int c = 0; c < 400; c++) begin
            clk_step();
            obs = {tick_b, tick_a, out_b, out_a, clip_b, clip_a}; want = exp_vec();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL async_restart c=%0d got=%b want=%b", c, obs, want);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_tick_period();
        test_unity_zero();
        test_strobe_on_tick();
        test_saturation();
        test_mute_fade();
        test_order2();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
